vga_line_fetch_ctrl: RTL and testbench

VGA_LINE_FETCH_CTRL -- requirements
Module: vga_line_fetch_ctrl

---
 rtl/vga_line_fetch_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_vga_line_fetch_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// vga_line_fetch_ctrl
//
// Purpose: fetches one video line per burst from a frame buffer into the line
// FIFO that feeds the pixel pipeline. A frame start (vs edge into VS_POL)
// flushes the FIFO and restarts at frame_base. Each following line is requested
// after the display has finished a line (de falling edge) and the FIFO has room
// for a whole line. The block also flags FIFO underflow while video is active.
//
// Optional feature: define LINE_FETCH_STATS_EN to build a saturating 16-bit
// counter of underflow cycles. Without the macro, underflow_cnt_o is tied to 0.
//
// Ports:
//   clk             pixel clock
//   rst_n           asynchronous active-low reset
//   vs_i            vertical sync from the timing generator
//   de_i            video-active from the timing generator
//   frame_base_i    byte address of line 0, captured at frame start
//   fifo_level_i    line-FIFO occupancy in pixels
//   fifo_empty_i    line-FIFO empty
//   rd_ack_i        memory accepted the current request
//   rd_done_i       pulse: last pixel of the accepted burst is in the FIFO
//   rd_req_o        burst read request
//   rd_addr_o       burst byte address
//   rd_len_o        burst length in pixels (always H_ACTIVE)
//   fifo_flush_o    one-cycle FIFO clear pulse
//   busy_o          high in any state other than IDLE
//   underflow_o     sticky underflow flag, cleared at the next flush
//   underflow_cnt_o underflow cycle count (0 unless LINE_FETCH_STATS_EN)
//   state_o         current FSM state, for debug and checkers
//
// Request handshake: rd_req_o rises in REQ and holds, with rd_addr_o and
// rd_len_o stable, until rd_ack_i is sampled high on a clock edge; it is low
// from the following cycle. rd_done_i is only honoured in WAIT_DONE.
// -----------------------------------------------------------------------------
module vga_line_fetch_ctrl #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LINE_STRIDE = 2560,
    parameter int unsigned FIFO_DEPTH  = 2048,
    parameter bit          VS_POL      = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [31:0] frame_base_i,
    input  logic [11:0] fifo_level_i,
    input  logic        fifo_empty_i,
    input  logic        rd_ack_i,
    input  logic        rd_done_i,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    output logic [11:0] rd_len_o,
    output logic        fifo_flush_o,
    output logic        busy_o,
    output logic        underflow_o,
    output logic [15:0] underflow_cnt_o,
    output logic [2:0]  state_o
);

    localparam int unsigned LCW = $clog2(V_ACTIVE + 1);
    // A new line is only requested when the FIFO can take all of it.
    localparam logic [11:0] LVL_MAX = 12'(FIFO_DEPTH - H_ACTIVE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FLUSH     = 3'd1,
        REQ       = 3'd2,
        WAIT_DONE = 3'd3,
        WAIT_LINE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             vs_q;
    logic             de_q;
    logic [31:0]      base_q;
    logic [31:0]      rd_addr_q;
    logic [LCW-1:0]   line_cnt_q;
    logic             pending_q;
    logic             seen_q;
    logic             underflow_q;

    logic frame_start;
    logic de_fall;
    logic level_ok;
    logic last_line;
    logic line_done;
    logic uf_cond;

    assign frame_start = (vs_i == VS_POL) && (vs_q != VS_POL);
    assign de_fall     = de_q && !de_i;
    assign level_ok    = (fifo_level_i <= LVL_MAX);
    assign last_line   = (line_cnt_q == LCW'(V_ACTIVE - 1));
    assign line_done   = (state_q == WAIT_DONE) && rd_done_i;
    assign uf_cond     = de_i && fifo_empty_i;

    // Next-state logic. A frame start seen during a transaction is held in
    // pending_q and honoured only once the burst has fully completed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_start) state_d = FLUSH;
            end
            FLUSH: begin
                state_d = REQ;
            end
            REQ: begin
                if (rd_ack_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (rd_done_i) begin
                    if (pending_q || frame_start) state_d = FLUSH;
                    else if (last_line)           state_d = IDLE;
                    else                          state_d = WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                if (frame_start)                          state_d = FLUSH;
                else if ((seen_q || de_fall) && level_ok) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= vs_i;
            de_q    <= de_i;
        end
    end

    // Base captured on every frame start so a deferred flush still uses the
    // address belonging to the frame that triggered it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
        end else if (frame_start) begin
            base_q <= frame_base_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q  <= '0;
            line_cnt_q <= '0;
        end else if (state_q == FLUSH) begin
            rd_addr_q  <= base_q;
            line_cnt_q <= '0;
        end else if (line_done) begin
            rd_addr_q  <= rd_addr_q + 32'(LINE_STRIDE);
            line_cnt_q <= line_cnt_q + LCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else if (state_q == FLUSH) begin
            pending_q <= 1'b0;
        end else if (frame_start && (state_q == REQ || state_q == WAIT_DONE)) begin
            pending_q <= 1'b1;
        end
    end

    // Remembers a de falling edge since entering WAIT_LINE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
        end else if (state_q != WAIT_LINE) begin
            seen_q <= 1'b0;
        end else if (de_fall) begin
            seen_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_q <= 1'b0;
        end else if (state_q == FLUSH) begin
            underflow_q <= 1'b0;
        end else if (uf_cond) begin
            underflow_q <= 1'b1;
        end
    end

`ifdef LINE_FETCH_STATS_EN
    logic [15:0] uf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf_cnt_q <= '0;
        end else if (state_q == FLUSH) begin
            uf_cnt_q <= '0;
        end else if (uf_cond && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_q <= uf_cnt_q + 16'd1;
        end
    end

    assign underflow_cnt_o = uf_cnt_q;
`else
    assign underflow_cnt_o = 16'd0;
`endif

    assign rd_req_o     = (state_q == REQ);
    assign rd_addr_o    = rd_addr_q;
    assign rd_len_o     = 12'(H_ACTIVE);
    assign fifo_flush_o = (state_q == FLUSH);
    assign busy_o       = (state_q != IDLE);
    assign underflow_o  = underflow_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
module tb_vga_line_fetch_ctrl;

  localparam int unsigned V_LINES = 8;
  localparam int unsigned STRIDE  = 2560;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        vs_i, de_i, fifo_empty_i, rd_ack_i, rd_done_i;
  logic [31:0] frame_base_i;
  logic [11:0] fifo_level_i;
  logic        rd_req_o, fifo_flush_o, busy_o, underflow_o;
  logic [31:0] rd_addr_o;
  logic [11:0] rd_len_o;
  logic [15:0] underflow_cnt_o;
  logic [2:0]  state_o;

  vga_line_fetch_ctrl #(
    .H_ACTIVE(640), .V_ACTIVE(V_LINES), .LINE_STRIDE(STRIDE),
    .FIFO_DEPTH(2048), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i),
    .frame_base_i(frame_base_i), .fifo_level_i(fifo_level_i),
    .fifo_empty_i(fifo_empty_i), .rd_ack_i(rd_ack_i), .rd_done_i(rd_done_i),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_len_o(rd_len_o),
    .fifo_flush_o(fifo_flush_o), .busy_o(busy_o), .underflow_o(underflow_o),
    .underflow_cnt_o(underflow_cnt_o), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int req_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(i) * 32'(STRIDE);
      exp_q.push_back(a);
    end
  endtask

  // ---------------- memory responder ----------------
  bit resp_en   = 1'b1;
  int ack_dly   = 2;
  int done_dly  = 30;
  bit done_seen = 1'b0;

  initial begin
    logic [31:0] hold_addr;
    logic [31:0] e;
    rd_ack_i  = 1'b0;
    rd_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && rst_n && rd_req_o) begin
        hold_addr = rd_addr_o;
        repeat (ack_dly) @(negedge clk);
        chk("req_held", {31'd0, rd_req_o}, 32'd1);
        chk("addr_stable", rd_addr_o, hold_addr);
        chk("rd_len", {20'd0, rd_len_o}, 32'd640);
        chk("req_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("req_addr", rd_addr_o, e);
        end
        req_cnt++;
        rd_ack_i = 1'b1;
        @(negedge clk);
        rd_ack_i = 1'b0;
        chk("req_drop", {31'd0, rd_req_o}, 32'd0);
        repeat (done_dly - 1) @(negedge clk);
        rd_done_i = 1'b1;
        @(negedge clk);
        rd_done_i = 1'b0;
        done_seen = 1'b1;
      end
    end
  end

  // ---------------- display timing (de) ----------------
  bit de_run = 1'b1;
  initial begin
    de_i = 1'b0;
    forever begin
      if (de_run) begin
        de_i = 1'b1;
        repeat (30) @(negedge clk);
        de_i = 1'b0;
        repeat (10) @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic frame_start(input logic [31:0] base);
    frame_base_i = base;
    vs_i = 1'b0;
    @(negedge clk);
    chk("flush_pulse", {31'd0, fifo_flush_o}, 32'd1);
    vs_i = 1'b1;
    @(negedge clk);
    chk("flush_one_cycle", {31'd0, fifo_flush_o}, 32'd0);
    chk("first_req", {31'd0, rd_req_o}, 32'd1);
    chk("first_addr", rd_addr_o, base);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int n = 0;
    while (state_o != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {29'd0, state_o}, {29'd0, st});
  endtask

  task automatic watch_no_req(input string tag, input int cycles);
    bit saw = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rd_req_o) saw = 1'b1;
    end
    chk(tag, {31'd0, saw}, 32'd0);
  endtask

  // global watchdog
  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] b;
    int n;
    int start_cnt;
    bit saw;
    logic [15:0] exp_cnt;

    rst_n = 1'b0;
    vs_i = 1'b1;
    frame_base_i = 32'h0;
    fifo_level_i = 12'd0;
    fifo_empty_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_req", {31'd0, rd_req_o}, 32'd0);
    chk("rst_rd_addr", rd_addr_o, 32'd0);
    chk("rst_rd_len", {20'd0, rd_len_o}, 32'd640);
    chk("rst_flush", {31'd0, fifo_flush_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_underflow", {31'd0, underflow_o}, 32'd0);
    chk("rst_uf_cnt", {16'd0, underflow_cnt_o}, 32'd0);
    chk("rst_state", {29'd0, state_o}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_req", {31'd0, rd_req_o}, 32'd0);

    // full frame, ack 2 cycles after request
    b = 32'h1000_0000;
    start_cnt = req_cnt;
    push_frame(b, V_LINES);
    frame_start(b);
    wait_idle("frame1_done", 20000);
    chk("frame1_reqs", 32'(req_cnt - start_cnt), 32'(V_LINES));
    chk("frame1_final_addr", rd_addr_o, b + 32'(V_LINES) * 32'(STRIDE));
    chk("frame1_queue_empty", 32'(exp_q.size()), 32'd0);

    // FIFO level gating: 1500 and 1409 block, 1408 releases
    b = 32'h2000_0000;
    start_cnt = req_cnt;
    fifo_level_i = 12'd1500;
    push_frame(b, V_LINES);
    frame_start(b);
    wait_state("lvl_wait_line", 3'd4, 300);
    watch_no_req("lvl1500_noreq", 150);
    fifo_level_i = 12'd1409;
    watch_no_req("lvl1409_noreq", 100);
    chk("lvl_one_req", 32'(req_cnt - start_cnt), 32'd1);
    fifo_level_i = 12'd1408;
    wait_idle("lvl_frame_done", 20000);
    chk("lvl_reqs", 32'(req_cnt - start_cnt), 32'(V_LINES));
    fifo_level_i = 12'd0;

    // frame start while waiting for rd_done
    b = 32'h3000_0000;
    done_dly = 200;
    push_frame(b, 1);
    frame_start(b);
    wait_state("pend_wait_done", 3'd3, 50);
    b = 32'h4000_4000;
    push_frame(b, V_LINES);
    start_cnt = req_cnt;
    done_seen = 1'b0;
    frame_base_i = b;
    vs_i = 1'b0;
    @(negedge clk);
    vs_i = 1'b1;
    frame_base_i = 32'hDEAD_0000;
    done_dly = 30;
    saw = 1'b0;
    n = 0;
    while (!fifo_flush_o && n < 400) begin
      if (rd_req_o) saw = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("pend_flush_seen", {31'd0, fifo_flush_o}, 32'd1);
    chk("pend_no_req", {31'd0, saw}, 32'd0);
    chk("pend_done_first", {31'd0, done_seen}, 32'd1);
    @(negedge clk);
    chk("pend_new_req", {31'd0, rd_req_o}, 32'd1);
    chk("pend_new_addr", rd_addr_o, b);
    wait_idle("pend_frame_done", 20000);
    chk("pend_reqs", 32'(req_cnt - start_cnt), 32'(V_LINES));

    // underflow: de=1 with fifo empty for 5 cycles
    de_run = 1'b0;
    repeat (50) @(negedge clk);
    de_i = 1'b0;
    @(negedge clk);
    chk("uf_clear_before", {31'd0, underflow_o}, 32'd0);
`ifdef LINE_FETCH_STATS_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    de_i = 1'b1;
    fifo_empty_i = 1'b1;
    @(negedge clk);
    chk("uf_latency", {31'd0, underflow_o}, 32'd1);
    repeat (4) @(negedge clk);
    de_i = 1'b0;
    fifo_empty_i = 1'b0;
    repeat (3) @(negedge clk);
    de_i = 1'b1;
    repeat (3) @(negedge clk);
    de_i = 1'b0;
    @(negedge clk);
    chk("uf_sticky", {31'd0, underflow_o}, 32'd1);
    chk("uf_cnt", {16'd0, underflow_cnt_o}, {16'd0, exp_cnt});
    de_run = 1'b1;
    b = 32'h5000_0000;
    start_cnt = req_cnt;
    push_frame(b, V_LINES);
    frame_start(b);
    chk("uf_cleared", {31'd0, underflow_o}, 32'd0);
    chk("uf_cnt_cleared", {16'd0, underflow_cnt_o}, 32'd0);
    wait_idle("uf_frame_done", 20000);
    chk("uf_reqs", 32'(req_cnt - start_cnt), 32'(V_LINES));

    // reset while requesting
    resp_en = 1'b0;
    frame_start(32'h6000_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, rd_req_o}, 32'd0);
    chk("arst_state", {29'd0, state_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_addr", rd_addr_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    watch_no_req("arst_no_req", 120);

    // frame from idle with 32-bit address wrap
    b = 32'hFFFF_F000;
    start_cnt = req_cnt;
    push_frame(b, V_LINES);
    frame_start(b);
    wait_idle("wrap_frame_done", 20000);
    chk("wrap_reqs", 32'(req_cnt - start_cnt), 32'(V_LINES));
    chk("wrap_final_addr", rd_addr_o, 32'hFFFF_F000 + 32'(V_LINES) * 32'(STRIDE));
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
